// File: rtl/ex3_decoder.sv
// Multi-digit excess-3 to BCD + binary decoder. Bias is stripped at accept time,
// then an iterative reverse double-dabble (shift right, digits >= 8 minus 3) yields binary.
module ex3_decoder #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_ex3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int WRK_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WRK_W-1:0]   work;
  logic [WRK_W-1:0]   shifted;
  logic [WRK_W-1:0]   adj;
  logic [BCD_W-1:0]   dec_bcd;
  logic [DIGITS-1:0]  dec_bad;

  assign shifted = work >> 1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] nib;
    logic [3:0] wd;
    assign nib = in_ex3[4*i +: 4];
    assign dec_bad[i] = (nib < 4'h3) || (nib > 4'hC);
    assign dec_bcd[4*i +: 4] = dec_bad[i] ? 4'h0 : nib - 4'h3;
    // Correction applies after the shift, to the BCD half only.
    assign wd = shifted[BIN_W + 4*i +: 4];
    assign adj[BIN_W + 4*i +: 4] = (wd >= 4'h8) ? wd - 4'h3 : wd;
  end
  assign adj[BIN_W-1:0] = shifted[BIN_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_bin   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            out_bcd  <= dec_bcd;
            out_bin  <= '0;
            out_err  <= |dec_bad;
            cnt      <= '0;
            if (|dec_bad) begin
              state <= DONE;
            end else begin
              state <= CONV;
              work  <= {dec_bcd, {BIN_W{1'b0}}};
            end
          end
        end
        CONV: begin
          work <= adj;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_bin   <= adj[BIN_W-1:0];
            out_err   <= 1'b0;
          end
        end
        DONE: begin
          // Error path enters DONE with out_valid low; it rises one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
